muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset.
REQ-002 Ports: clk  in  1  rising-edge clock.
REQ-003 Ports: rst_n  in  1  async active-low reset.
REQ-004 Ports: start  in  1  request strobe, sampled on rising clk.
REQ-005 Ports: op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
REQ-006 Ports: cancel  in  1  pipeline flush; aborts an in-flight operation.
REQ-007 Ports: a  in  32  rs operand (multiplicand/dividend/MTxx data).
REQ-008 Ports: b  in  32  rt operand (multiplier/divisor).
REQ-009 Ports: busy  out  1  high while state != IDLE; drives pipeline stall.
REQ-010 Ports: done  out  1  registered one-cycle completion pulse.
REQ-011 Ports: hi  out  32  HI register; lo  out  32  LO register.

Function
REQ-012 States SHALL be IDLE, CALC, FIN; busy = (state != IDLE).
REQ-013 Accept edge E0: state IDLE, start=1, cancel=0, op in {MULT,MULTU,DIV,DIVU} -> a, b, op latched; signed ops latch magnitudes plus sign bits; iteration count <= 0; state -> CALC.
REQ-014 MTHI/MTLO with start=1 in IDLE SHALL write a into hi/lo at E0; no busy, no done; other register unchanged.
REQ-015 Reserved op with start=1 SHALL be ignored (no state change).
REQ-016 start while busy SHALL be ignored; no queuing; requester re-issues after busy falls.
REQ-017 CALC SHALL perform exactly one radix-2 iteration per edge E1..E32 (shift-add for multiply, restoring shift-subtract for divide); after E32 -> FIN.
REQ-018 At E33 (leaving FIN) hi/lo SHALL be written, done <= 1, state -> IDLE; done <= 0 at E34.
REQ-019 Latency: results visible and done high in the cycle after E33; busy low in that same cycle; fixed 33 busy cycles for all mul/div ops.
REQ-020 MULT/MULTU: {hi,lo} = full 64-bit product; MULT negates the 64-bit magnitude product when sign(a) XOR sign(b).
REQ-021 DIV/DIVU: lo = quotient, hi = remainder; DIV quotient sign = sign(a) XOR sign(b), remainder sign = sign(a), truncation toward zero.
REQ-022 DIV of 0x8000_0000 by 0xFFFF_FFFF SHALL give lo=0x8000_0000, hi=0.
REQ-023 Divide by zero (DIV or DIVU) SHALL run full latency and give lo=0xFFFF_FFFF, hi=a.
REQ-024 cancel=1 in CALC or FIN SHALL return state to IDLE on the next edge; hi/lo unchanged; no done pulse.
REQ-025 cancel=1 and start=1 in the same IDLE cycle: cancel wins; no write (including MTHI/MTLO).
REQ-026 Operand inputs SHALL be don't-care after E0; internal copies only used.
REQ-027 hi/lo SHALL change only at REQ-014 or REQ-018 edges.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, iteration count=0, internal operand registers=0.
REQ-029 Reset asserted mid-operation SHALL discard the operation; no done after release.
REQ-030 First start SHALL be accepted on the first rising clk with rst_n high.

Verification
REQ-031 MULT a=0xFFFF_FFFE (-2), b=3 -> after 33 busy cycles done=1, hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; MULTU same operands -> hi=0x0000_0002, lo=0xFFFF_FFFA.
REQ-032 DIV a=-7 (0xFFFF_FFF9), b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIVU a=7, b=0 -> lo=0xFFFF_FFFF, hi=7.
REQ-033 MTHI a=0x1234_5678 in IDLE -> hi=0x1234_5678 next cycle, busy=0, done=0; then start MULTU while busy -> ignored, first result unaffected.
REQ-034 MULTU a=b=0xFFFF_FFFF with cancel at cycle 10 -> busy low next cycle, hi/lo retain prior values, done never asserted.
REQ-035 rst_n low at cycle 20 of DIV -> all outputs 0 immediately; after release no done; new DIVU 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
// The master side (pipeline) drives the request fields.
// The slave side (muldiv_ctrl) drives status and the HI/LO registers.
interface muldiv_ctrl_if;
   logic        i_start;
   logic [2:0]  i_op;
   logic        i_cancel;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_hi;
   logic [31:0] o_lo;

   modport master (
      output i_start, i_op, i_cancel, i_a, i_b,
      input  o_busy, o_done, o_hi, o_lo
   );

   modport slave (
      input  i_start, i_op, i_cancel, i_a, i_b,
      output o_busy, o_done, o_hi, o_lo
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// Every mul/div operation takes a fixed 33 busy cycles:
//   - 32 radix-2 iterations in CALC;
//   - one FIN cycle that applies the sign fix-up and writes HI/LO.
// Signed operations work on operand magnitudes and correct the signs at the end.
module muldiv_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_ctrl_if.slave bus
);
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIN = 2'b10} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [4:0]  r_cnt;
   logic        r_is_div;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [63:0] r_acc;
   logic [31:0] r_opnd;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;

   logic        w_accept;
   logic        w_mthi;
   logic        w_mtlo;
   logic        w_step;
   logic        w_finish;

   logic        w_signed;
   logic        w_op_div;
   logic        w_div_zero;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;

   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_nxt;
   logic [32:0] w_rem_sh;
   logic        w_rem_ge;
   logic [31:0] w_rem_sub;
   logic [63:0] w_div_nxt;

   logic [63:0] w_prod;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   // FSM next-state and per-cycle control strobes; cancel always takes priority
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_mthi      = 1'b0;
      w_mtlo      = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_start && !bus.i_cancel) begin
               case (bus.i_op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     w_accept    = 1'b1;
                     w_state_nxt = CALC;
                  end
                  OP_MTHI: w_mthi = 1'b1;
                  OP_MTLO: w_mtlo = 1'b1;
                  default: w_state_nxt = IDLE;
               endcase
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CALC: begin
            if (bus.i_cancel) begin
               w_state_nxt = IDLE;
            end else begin
               w_step = 1'b1;
               if (r_cnt == 5'd31) begin
                  w_state_nxt = FIN;
               end else begin
                  w_state_nxt = CALC;
               end
            end
         end
         FIN: begin
            if (bus.i_cancel) begin
               w_state_nxt = IDLE;
            end else begin
               w_finish    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand preparation at accept: magnitudes and sign flags.
   // Divide-by-zero keeps the raw dividend, so the unsigned loop returns
   // quotient all-ones and remainder = a with no sign fix-up needed.
   always_comb begin
      w_signed   = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
      w_op_div   = (bus.i_op == OP_DIV) || (bus.i_op == OP_DIVU);
      w_div_zero = w_op_div && (bus.i_b == 32'd0);
      w_a_neg    = w_signed && bus.i_a[31] && !w_div_zero;
      w_b_neg    = w_signed && bus.i_b[31] && !w_div_zero;
      w_a_mag    = w_a_neg ? (32'd0 - bus.i_a) : bus.i_a;
      w_b_mag    = w_b_neg ? (32'd0 - bus.i_b) : bus.i_b;
   end

   // One radix-2 iteration of each datapath.
   // Multiply: r_acc = {partial product, multiplier}.
   // Divide:   r_acc = {remainder, dividend/quotient}.
   always_comb begin
      w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
      w_mul_nxt = {w_mul_sum, r_acc[31:1]};
      w_rem_sh  = {r_acc[63:32], r_acc[31]};
      w_rem_ge  = (w_rem_sh >= {1'b0, r_opnd});
      w_rem_sub = w_rem_sh[31:0] - r_opnd;
      if (w_rem_ge) begin
         w_div_nxt = {w_rem_sub, r_acc[30:0], 1'b1};
      end else begin
         w_div_nxt = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
      end
   end

   // Final sign correction of the magnitude result
   always_comb begin
      w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
      if (r_is_div) begin
         w_res_lo = r_neg_q ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
         w_res_hi = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
      end else begin
         w_res_hi = w_prod[63:32];
         w_res_lo = w_prod[31:0];
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand latch, iteration datapath, HI/LO writes and the done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= 5'd0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_acc    <= 64'd0;
         r_opnd   <= 32'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_cnt    <= 5'd0;
            r_is_div <= w_op_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_op_div) begin
               r_acc  <= {32'd0, w_a_mag};
               r_opnd <= w_b_mag;
            end else begin
               r_acc  <= {32'd0, w_b_mag};
               r_opnd <= w_a_mag;
            end
         end else if (w_step) begin
            r_cnt <= r_cnt + 5'd1;
            r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
         end
         if (w_finish) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else if (w_mthi) begin
            r_hi <= bus.i_a;
         end else if (w_mtlo) begin
            r_lo <= bus.i_a;
         end
      end
   end

   assign bus.o_busy = (r_state != IDLE);
   assign bus.o_done = r_done;
   assign bus.o_hi   = r_hi;
   assign bus.o_lo   = r_lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl.
// It runs a table of directed vectors and randomized unsigned/signed vectors.
// It also exercises hand sequences for MTHI/MTLO, reserved ops,
// cancel, and reset in mid-operation.
// Expected HI/LO pairs go through a scoreboard queue.
module tb_muldiv_ctrl;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;
   logic [63:0] sb_q[$];

   always #5 clk = ~clk;

   muldiv_ctrl_if bus();

   muldiv_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Issue one mul/div op, push its expectation, then wait for done.
   // poke_at >= 0 fires a stray start after that many busy cycles.
   task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int poke_at);
      int n;
      logic [63:0] exp;
      sb_q.push_back({ehi, elo});
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_a     = a;
      bus.i_b     = b;
      tick();
      bus.i_start = 1'b0;
      bus.i_a     = $urandom;
      bus.i_b     = $urandom;
      n = 0;
      while (bus.o_busy === 1'b1 && n < 100) begin
         if (n == poke_at) begin
            bus.i_start = 1'b1;
            bus.i_op    = OP_DIVU;
         end
         tick();
         bus.i_start = 1'b0;
         n++;
      end
      chk({nm, " busy_cycles"}, 64'(n), 64'd33);
      chk({nm, " done_high"}, 64'(bus.o_done), 64'd1);
      exp = sb_q.pop_front();
      chk({nm, " hi"}, 64'(bus.o_hi), 64'(exp[63:32]));
      chk({nm, " lo"}, 64'(bus.o_lo), 64'(exp[31:0]));
      tick();
      chk({nm, " done_pulse_end"}, 64'(bus.o_done), 64'd0);
   endtask

   initial begin
      vec_t vecs[13];
      logic [31:0] prev_hi;
      logic [31:0] prev_lo;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] p;
      logic signed [63:0] sp;
      logic [31:0] sq;
      logic [31:0] sr;
      int saw_done;

      vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
      vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
      vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
      vecs[6]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[7]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[8]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[10] = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
      vecs[12] = '{OP_MULT,  32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

      bus.i_start  = 1'b0;
      bus.i_op     = 3'b000;
      bus.i_cancel = 1'b0;
      bus.i_a      = 32'd0;
      bus.i_b      = 32'd0;
      tick();
      tick();
      chk("reset busy", 64'(bus.o_busy), 64'd0);
      chk("reset done", 64'(bus.o_done), 64'd0);
      chk("reset hi", 64'(bus.o_hi), 64'd0);
      chk("reset lo", 64'(bus.o_lo), 64'd0);
      rst_n = 1'b1;

      // MTHI on the first edge after reset release, then MTLO
      bus.i_start = 1'b1;
      bus.i_op    = OP_MTHI;
      bus.i_a     = 32'h1234_5678;
      tick();
      bus.i_start = 1'b0;
      chk("mthi hi", 64'(bus.o_hi), 64'h1234_5678);
      chk("mthi lo_kept", 64'(bus.o_lo), 64'd0);
      chk("mthi busy", 64'(bus.o_busy), 64'd0);
      chk("mthi done", 64'(bus.o_done), 64'd0);
      bus.i_start = 1'b1;
      bus.i_op    = OP_MTLO;
      bus.i_a     = 32'hCAFE_F00D;
      tick();
      bus.i_start = 1'b0;
      chk("mtlo lo", 64'(bus.o_lo), 64'hCAFE_F00D);
      chk("mtlo hi_kept", 64'(bus.o_hi), 64'h1234_5678);

      // cancel beats start in IDLE, MTHI included
      bus.i_start  = 1'b1;
      bus.i_cancel = 1'b1;
      bus.i_op     = OP_MTHI;
      bus.i_a      = 32'hDEAD_BEEF;
      tick();
      bus.i_start  = 1'b0;
      bus.i_cancel = 1'b0;
      chk("cancel_start hi", 64'(bus.o_hi), 64'h1234_5678);
      bus.i_start  = 1'b1;
      bus.i_cancel = 1'b1;
      bus.i_op     = OP_DIVU;
      tick();
      bus.i_start  = 1'b0;
      bus.i_cancel = 1'b0;
      chk("cancel_start busy", 64'(bus.o_busy), 64'd0);

      // reserved ops are ignored
      for (int k = 6; k < 8; k++) begin
         bus.i_start = 1'b1;
         bus.i_op    = 3'(k);
         bus.i_a     = 32'h5555_AAAA;
         tick();
         bus.i_start = 1'b0;
         chk($sformatf("reserved%0d busy", k), 64'(bus.o_busy), 64'd0);
         chk($sformatf("reserved%0d hilo", k), {bus.o_hi, bus.o_lo}, 64'h1234_5678_CAFE_F00D);
      end

      for (int i = 0; i < 13; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, -1);
      end

      // stray start while busy is ignored
      run_op("ignored_start", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5);

      // cancel after 10 busy cycles: no write, no done
      prev_hi = bus.o_hi;
      prev_lo = bus.o_lo;
      bus.i_start = 1'b1;
      bus.i_op    = OP_MULTU;
      bus.i_a     = 32'hFFFF_FFFF;
      bus.i_b     = 32'hFFFF_FFFF;
      tick();
      bus.i_start = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      chk("cancel busy_before", 64'(bus.o_busy), 64'd1);
      bus.i_cancel = 1'b1;
      tick();
      bus.i_cancel = 1'b0;
      chk("cancel busy_after", 64'(bus.o_busy), 64'd0);
      chk("cancel hilo_kept", {bus.o_hi, bus.o_lo}, {prev_hi, prev_lo});
      saw_done = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.o_done === 1'b1) saw_done = 1;
         tick();
      end
      chk("cancel no_done", 64'(saw_done), 64'd0);

      // reset 20 cycles into a DIV
      bus.i_start = 1'b1;
      bus.i_op    = OP_DIV;
      bus.i_a     = 32'd1000;
      bus.i_b     = 32'd3;
      tick();
      bus.i_start = 1'b0;
      for (int k = 0; k < 19; k++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset outputs", {30'd0, bus.o_busy, bus.o_done, bus.o_hi}, 64'd0);
      chk("midreset lo", 64'(bus.o_lo), 64'd0);
      tick();
      rst_n = 1'b1;
      saw_done = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) saw_done = 1;
         tick();
      end
      chk("midreset no_done", 64'(saw_done), 64'd0);
      run_op("after_reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, -1);

      // randomized vectors with expectations from native arithmetic
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         p  = 64'(ra) * 64'(rb);
         run_op($sformatf("rnd_multu%0d", i), OP_MULTU, ra, rb, p[63:32], p[31:0], -1);
         sp = $signed(ra) * $signed(rb);
         run_op($sformatf("rnd_mult%0d", i), OP_MULT, ra, rb, sp[63:32], sp[31:0], -1);
         rb = $urandom_range(1, 65535);
         if (i[0]) rb = rb | 32'h0100_0000;
         run_op($sformatf("rnd_divu%0d", i), OP_DIVU, ra, rb, ra % rb, ra / rb, -1);
         if (i[1]) rb = 32'd0 - rb;
         sq = $signed(ra) / $signed(rb);
         sr = $signed(ra) % $signed(rb);
         run_op($sformatf("rnd_div%0d", i), OP_DIV, ra, rb, sr, sq, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
